// File: rtl/uart_cmd_ctrl.sv
// Command sequencer between the UART RX/TX byte streams and the register file / ALU.
// Parses command frames, issues RF/ALU strobes, and queues response bytes to the TX FIFO.
module uart_cmd_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int FUN_WIDTH  = 4,
  parameter logic [DATA_WIDTH-1:0] CMD_RF_WR   = 8'hAA,
  parameter logic [DATA_WIDTH-1:0] CMD_RF_RD   = 8'hBB,
  parameter logic [DATA_WIDTH-1:0] CMD_ALU_OP  = 8'hCC,
  parameter logic [DATA_WIDTH-1:0] CMD_ALU_NOP = 8'hDD
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [DATA_WIDTH-1:0]   RX_P_DATA,
  input  logic                    RX_D_VLD,
  output logic [ADDR_WIDTH-1:0]   RF_ADDR,
  output logic                    RF_WR_EN,
  output logic [DATA_WIDTH-1:0]   RF_WR_DATA,
  output logic                    RF_RD_EN,
  input  logic [DATA_WIDTH-1:0]   RF_RD_DATA,
  input  logic                    RF_RD_VLD,
  output logic                    ALU_EN,
  output logic [FUN_WIDTH-1:0]    ALU_FUN,
  input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
  input  logic                    ALU_OUT_VLD,
  output logic                    CLK_GATE_EN,
  output logic [DATA_WIDTH-1:0]   TX_WR_DATA,
  output logic                    TX_WR_EN,
  input  logic                    TX_FIFO_FULL
);

  typedef enum logic [3:0] {
    IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, RD_SEND,
    OP_A, OP_B, OP_FUN, ALU_WAIT, SEND_LO, SEND_HI
  } state_t;

  state_t                  state, state_nx;
  logic [ADDR_WIDTH-1:0]   rf_addr_nx;
  logic [DATA_WIDTH-1:0]   rf_wr_data_nx;
  logic                    rf_wr_en_nx;
  logic                    rf_rd_en_nx;
  logic                    alu_en_nx;
  logic [FUN_WIDTH-1:0]    alu_fun_nx;
  logic                    gate_nx;
  logic [DATA_WIDTH-1:0]   tx_data_nx;
  logic                    tx_wr_en_nx;
  logic                    res_ld;
  logic [2*DATA_WIDTH-1:0] res_nx;
  logic [2*DATA_WIDTH-1:0] res_q;

  always_comb begin
    state_nx      = state;
    rf_addr_nx    = RF_ADDR;
    rf_wr_data_nx = RF_WR_DATA;
    rf_wr_en_nx   = 1'b0;
    rf_rd_en_nx   = 1'b0;
    alu_en_nx     = 1'b0;
    alu_fun_nx    = ALU_FUN;
    gate_nx       = CLK_GATE_EN;
    tx_data_nx    = TX_WR_DATA;
    tx_wr_en_nx   = 1'b0;
    res_ld        = 1'b0;
    res_nx        = res_q;
    case (state)
      IDLE: if (RX_D_VLD) begin
        case (RX_P_DATA)
          CMD_RF_WR:   state_nx = WR_ADDR;
          CMD_RF_RD:   state_nx = RD_ADDR;
          CMD_ALU_OP:  state_nx = OP_A;
          CMD_ALU_NOP: state_nx = OP_FUN;
          default:     state_nx = IDLE;
        endcase
      end
      WR_ADDR: if (RX_D_VLD) begin
        rf_addr_nx = RX_P_DATA[ADDR_WIDTH-1:0];
        state_nx   = WR_DATA;
      end
      WR_DATA: if (RX_D_VLD) begin
        rf_wr_data_nx = RX_P_DATA;
        rf_wr_en_nx   = 1'b1;
        state_nx      = IDLE;
      end
      RD_ADDR: if (RX_D_VLD) begin
        rf_addr_nx  = RX_P_DATA[ADDR_WIDTH-1:0];
        rf_rd_en_nx = 1'b1;
        state_nx    = RD_WAIT;
      end
      RD_WAIT: if (RF_RD_VLD) begin
        res_ld   = 1'b1;
        res_nx   = {{DATA_WIDTH{1'b0}}, RF_RD_DATA};
        state_nx = RD_SEND;
      end
      RD_SEND: if (!TX_FIFO_FULL) begin
        tx_wr_en_nx = 1'b1;
        tx_data_nx  = res_q[DATA_WIDTH-1:0];
        state_nx    = IDLE;
      end
      // Operands of CMD_ALU_OP land in RF addresses 0 and 1, where the ALU reads them
      OP_A: if (RX_D_VLD) begin
        rf_addr_nx    = '0;
        rf_wr_data_nx = RX_P_DATA;
        rf_wr_en_nx   = 1'b1;
        state_nx      = OP_B;
      end
      OP_B: if (RX_D_VLD) begin
        rf_addr_nx    = ADDR_WIDTH'(1);
        rf_wr_data_nx = RX_P_DATA;
        rf_wr_en_nx   = 1'b1;
        state_nx      = OP_FUN;
      end
      OP_FUN: if (RX_D_VLD) begin
        alu_en_nx  = 1'b1;
        alu_fun_nx = RX_P_DATA[FUN_WIDTH-1:0];
        gate_nx    = 1'b1;
        state_nx   = ALU_WAIT;
      end
      // Gate stays open through the capture cycle, closes the cycle after
      ALU_WAIT: if (ALU_OUT_VLD) begin
        res_ld   = 1'b1;
        res_nx   = ALU_OUT;
        gate_nx  = 1'b0;
        state_nx = SEND_LO;
      end
      SEND_LO: if (!TX_FIFO_FULL) begin
        tx_wr_en_nx = 1'b1;
        tx_data_nx  = res_q[DATA_WIDTH-1:0];
        state_nx    = SEND_HI;
      end
      SEND_HI: if (!TX_FIFO_FULL) begin
        tx_wr_en_nx = 1'b1;
        tx_data_nx  = res_q[2*DATA_WIDTH-1:DATA_WIDTH];
        state_nx    = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state       <= IDLE;
      RF_ADDR     <= '0;
      RF_WR_DATA  <= '0;
      RF_WR_EN    <= 1'b0;
      RF_RD_EN    <= 1'b0;
      ALU_EN      <= 1'b0;
      ALU_FUN     <= '0;
      CLK_GATE_EN <= 1'b0;
      TX_WR_DATA  <= '0;
      TX_WR_EN    <= 1'b0;
    end else begin
      state       <= state_nx;
      RF_ADDR     <= rf_addr_nx;
      RF_WR_DATA  <= rf_wr_data_nx;
      RF_WR_EN    <= rf_wr_en_nx;
      RF_RD_EN    <= rf_rd_en_nx;
      ALU_EN      <= alu_en_nx;
      ALU_FUN     <= alu_fun_nx;
      CLK_GATE_EN <= gate_nx;
      TX_WR_DATA  <= tx_data_nx;
      TX_WR_EN    <= tx_wr_en_nx;
    end
  end

  always_ff @(posedge CLK) begin
    if (res_ld) res_q <= res_nx;
  end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Bench for uart_cmd_ctrl: command frames from a vector table plus hand sequences,
// RF/ALU responders, and a scoreboard of expected RF writes, reads, ALU functions and TX bytes.
module tb_uart_cmd_ctrl;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [7:0]  RX_P_DATA = 8'h00;
  logic        RX_D_VLD = 1'b0;
  logic [3:0]  RF_ADDR;
  logic        RF_WR_EN;
  logic [7:0]  RF_WR_DATA;
  logic        RF_RD_EN;
  logic [7:0]  RF_RD_DATA = 8'h00;
  logic        RF_RD_VLD = 1'b0;
  logic        ALU_EN;
  logic [3:0]  ALU_FUN;
  logic [15:0] ALU_OUT = 16'h0000;
  logic        ALU_OUT_VLD = 1'b0;
  logic        CLK_GATE_EN;
  logic [7:0]  TX_WR_DATA;
  logic        TX_WR_EN;
  logic        TX_FIFO_FULL = 1'b0;

  uart_cmd_ctrl dut (
    .CLK(CLK), .RST(RST),
    .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
    .RF_ADDR(RF_ADDR), .RF_WR_EN(RF_WR_EN), .RF_WR_DATA(RF_WR_DATA),
    .RF_RD_EN(RF_RD_EN), .RF_RD_DATA(RF_RD_DATA), .RF_RD_VLD(RF_RD_VLD),
    .ALU_EN(ALU_EN), .ALU_FUN(ALU_FUN), .ALU_OUT(ALU_OUT), .ALU_OUT_VLD(ALU_OUT_VLD),
    .CLK_GATE_EN(CLK_GATE_EN),
    .TX_WR_DATA(TX_WR_DATA), .TX_WR_EN(TX_WR_EN), .TX_FIFO_FULL(TX_FIFO_FULL)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    int          nb;    // frame length
    logic [31:0] bs;    // frame bytes, first byte in [31:24]
    int          nw;    // expected RF writes
    logic [11:0] w0;    // {addr, data}
    logic [11:0] w1;
    bit          rd;    // expected RF read
    logic [3:0]  ra;
    int          nt;    // expected TX bytes
    logic [15:0] tx;    // first pushed byte in [15:8]
    bit          alu;   // expected ALU start
    logic [3:0]  fun;
  } vec_t;

  vec_t        vecs [8];
  logic [11:0] wr_q [$];
  logic [3:0]  rd_q [$];
  logic [3:0]  fun_q [$];
  logic [7:0]  tx_q [$];
  logic [7:0]  rf_mem [16];

  int n_chk = 0;
  int n_fail = 0;

  int         rd_cnt = 0;
  logic [3:0] rd_lat = 4'h0;
  int         alu_cnt = 0;
  logic [3:0] alu_fun_lat = 4'h0;
  int         full_cnt = 0;
  bit         full_after = 1'b0;
  bit         gm = 1'b0;

  function automatic vec_t mk(int nb, logic [31:0] bs, int nw, logic [11:0] w0, logic [11:0] w1,
                              bit rd, logic [3:0] ra, int nt, logic [15:0] tx, bit alu,
                              logic [3:0] fun);
    vec_t v;
    v.nb = nb; v.bs = bs; v.nw = nw; v.w0 = w0; v.w1 = w1; v.rd = rd; v.ra = ra;
    v.nt = nt; v.tx = tx; v.alu = alu; v.fun = fun;
    return v;
  endfunction

  function automatic logic [15:0] alu_model(logic [7:0] a, logic [7:0] b, logic [3:0] f);
    case (f)
      4'h0:    return {8'h00, a} + {8'h00, b};
      4'h1:    return {8'h00, a} - {8'h00, b};
      4'h2:    return {8'h00, a} * {8'h00, b};
      default: return {a, b};
    endcase
  endfunction

  // One clock: drive inputs just after the rising edge, check outputs on the falling edge.
  task automatic tick(input bit vld, input logic [7:0] data);
    @(posedge CLK);
    #1;
    RX_D_VLD  = vld;
    RX_P_DATA = data;
    RF_RD_VLD = 1'b0;
    ALU_OUT_VLD = 1'b0;
    if (!RST) begin
      rd_cnt = 0; alu_cnt = 0;
    end
    if (rd_cnt > 0) begin
      rd_cnt--;
      if (rd_cnt == 0) begin
        RF_RD_VLD  = 1'b1;
        RF_RD_DATA = rf_mem[rd_lat];
      end
    end
    if (RF_RD_EN) begin
      rd_cnt = 2; rd_lat = RF_ADDR;
    end
    if (full_cnt > 0) begin
      full_cnt--;
      if (full_cnt == 0) TX_FIFO_FULL = 1'b0;
    end
    if (alu_cnt > 0) begin
      alu_cnt--;
      if (alu_cnt == 0) begin
        ALU_OUT     = alu_model(rf_mem[0], rf_mem[1], alu_fun_lat);
        ALU_OUT_VLD = 1'b1;
        if (full_after) begin
          TX_FIFO_FULL = 1'b1; full_cnt = 11; full_after = 1'b0;
        end
      end
    end
    if (ALU_EN) begin
      alu_cnt = 3; alu_fun_lat = ALU_FUN;
    end

    @(negedge CLK);
    if (!RST) begin
      gm = 1'b0;
      n_chk++;
      if ({RF_ADDR, RF_WR_EN, RF_WR_DATA, RF_RD_EN, ALU_EN, ALU_FUN, CLK_GATE_EN,
           TX_WR_DATA, TX_WR_EN} != '0) begin
        n_fail++;
        $display("FAIL reset_outputs: got addr=%h wr=%b wd=%h rd=%b alu=%b fun=%h gate=%b txd=%h txw=%b required all zero",
                 RF_ADDR, RF_WR_EN, RF_WR_DATA, RF_RD_EN, ALU_EN, ALU_FUN, CLK_GATE_EN,
                 TX_WR_DATA, TX_WR_EN);
      end
    end else begin
      n_chk++;
      if (int'(RF_WR_EN) + int'(RF_RD_EN) + int'(ALU_EN) + int'(TX_WR_EN) > 1) begin
        n_fail++;
        $display("FAIL strobe_onehot: got wr=%b rd=%b alu=%b tx=%b required at most one",
                 RF_WR_EN, RF_RD_EN, ALU_EN, TX_WR_EN);
      end
      if (ALU_EN) gm = 1'b1;
      n_chk++;
      if (CLK_GATE_EN !== gm) begin
        n_fail++;
        $display("FAIL clk_gate_en: got %b required %b", CLK_GATE_EN, gm);
      end
      if (ALU_OUT_VLD) gm = 1'b0;
      if (RF_WR_EN) begin
        rf_mem[RF_ADDR] = RF_WR_DATA;
        n_chk++;
        if (wr_q.size() == 0) begin
          n_fail++;
          $display("FAIL rf_write_unexpected: got addr=%h data=%h required none", RF_ADDR, RF_WR_DATA);
        end else begin
          logic [11:0] e;
          e = wr_q.pop_front();
          if ({RF_ADDR, RF_WR_DATA} !== e) begin
            n_fail++;
            $display("FAIL rf_write: got %h required %h", {RF_ADDR, RF_WR_DATA}, e);
          end
        end
      end
      if (RF_RD_EN) begin
        n_chk++;
        if (rd_q.size() == 0) begin
          n_fail++;
          $display("FAIL rf_read_unexpected: got addr=%h required none", RF_ADDR);
        end else begin
          logic [3:0] e;
          e = rd_q.pop_front();
          if (RF_ADDR !== e) begin
            n_fail++;
            $display("FAIL rf_read_addr: got %h required %h", RF_ADDR, e);
          end
        end
      end
      if (ALU_EN) begin
        n_chk++;
        if (fun_q.size() == 0) begin
          n_fail++;
          $display("FAIL alu_start_unexpected: got fun=%h required none", ALU_FUN);
        end else begin
          logic [3:0] e;
          e = fun_q.pop_front();
          if (ALU_FUN !== e) begin
            n_fail++;
            $display("FAIL alu_fun: got %h required %h", ALU_FUN, e);
          end
        end
      end
      if (TX_WR_EN) begin
        n_chk++;
        if (TX_FIFO_FULL) begin
          n_fail++;
          $display("FAIL tx_push_while_full: got push with full=%b required full=0", TX_FIFO_FULL);
        end
        n_chk++;
        if (tx_q.size() == 0) begin
          n_fail++;
          $display("FAIL tx_push_unexpected: got %h required none", TX_WR_DATA);
        end else begin
          logic [7:0] e;
          e = tx_q.pop_front();
          if (TX_WR_DATA !== e) begin
            n_fail++;
            $display("FAIL tx_data: got %h required %h", TX_WR_DATA, e);
          end
        end
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    tick(1'b1, b);
    tick(1'b0, 8'h00);
  endtask

  task automatic wait_done(input string name);
    int k = 0;
    while ((wr_q.size() + rd_q.size() + fun_q.size() + tx_q.size()) != 0 && k < 300) begin
      tick(1'b0, 8'h00);
      k++;
    end
    n_chk++;
    if (k >= 300) begin
      n_fail++;
      $display("FAIL %s_timeout: got %0d outstanding events required 0", name,
               wr_q.size() + rd_q.size() + fun_q.size() + tx_q.size());
      wr_q.delete(); rd_q.delete(); fun_q.delete(); tx_q.delete();
    end
    repeat (8) tick(1'b0, 8'h00);
  endtask

  task automatic run_vec(input vec_t v, input string name);
    if (v.nw > 0) wr_q.push_back(v.w0);
    if (v.nw > 1) wr_q.push_back(v.w1);
    if (v.rd) rd_q.push_back(v.ra);
    if (v.alu) fun_q.push_back(v.fun);
    for (int i = 0; i < v.nt; i++) tx_q.push_back(v.tx[15-8*i -: 8]);
    for (int i = 0; i < v.nb; i++) send_byte(v.bs[31-8*i -: 8]);
    wait_done(name);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rf_mem[i] = 8'h00;

    vecs[0] = mk(3, 32'hAA053C00, 1, 12'h53C, 12'h000, 0, 4'h0, 0, 16'h0000, 0, 4'h0);
    vecs[1] = mk(2, 32'hBB050000, 0, 12'h000, 12'h000, 1, 4'h5, 1, 16'h3C00, 0, 4'h0);
    vecs[2] = mk(4, 32'hCC0A0300, 2, 12'h00A, 12'h103, 0, 4'h0, 2, 16'h0D00, 1, 4'h0);
    vecs[3] = mk(4, 32'h55AA01FF, 1, 12'h1FF, 12'h000, 0, 4'h0, 0, 16'h0000, 0, 4'h0);
    vecs[4] = mk(4, 32'hCCF02002, 2, 12'h0F0, 12'h120, 0, 4'h0, 2, 16'h001E, 1, 4'h2);
    vecs[5] = mk(4, 32'hCC103001, 2, 12'h010, 12'h130, 0, 4'h0, 2, 16'hE0FF, 1, 4'h1);
    vecs[6] = mk(2, 32'hBB010000, 0, 12'h000, 12'h000, 1, 4'h1, 1, 16'h3000, 0, 4'h0);
    vecs[7] = mk(1, 32'h12000000, 0, 12'h000, 12'h000, 0, 4'h0, 0, 16'h0000, 0, 4'h0);

    RST = 1'b0;
    repeat (3) tick(1'b0, 8'h00);
    RST = 1'b1;
    repeat (2) tick(1'b0, 8'h00);

    for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Stored operands 10,30 with mul; FIFO full for 11 cycles from result capture
    full_after = 1'b1;
    fun_q.push_back(4'h2);
    tx_q.push_back(8'h00);
    tx_q.push_back(8'h03);
    send_byte(8'hDD);
    send_byte(8'h02);
    wait_done("alu_full");

    // A byte arriving while waiting for the ALU is dropped
    fun_q.push_back(4'h0);
    tx_q.push_back(8'h40);
    tx_q.push_back(8'h00);
    send_byte(8'hDD);
    send_byte(8'h00);
    send_byte(8'hAA);
    wait_done("alu_drop");
    run_vec(vecs[6], "read_after_drop");

    // Reset in the middle of a write frame discards it
    send_byte(8'hAA);
    send_byte(8'h02);
    RST = 1'b0;
    repeat (3) tick(1'b0, 8'h00);
    RST = 1'b1;
    tick(1'b0, 8'h00);
    send_byte(8'h11);
    repeat (4) tick(1'b0, 8'h00);
    run_vec(mk(3, 32'hAA027700, 1, 12'h277, 12'h000, 0, 4'h0, 0, 16'h0000, 0, 4'h0), "write_after_reset");
    run_vec(mk(2, 32'hBB020000, 0, 12'h000, 12'h000, 1, 4'h2, 1, 16'h7700, 0, 4'h0), "read_after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
